// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: synchronizes the active-low rows, walks a one-cold column
// on a divided scan tick, debounces press and release, and hands accepted keys to a consumer.
module keypad_scan #(
    parameter int SCAN_DIV_W     = 15,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       key_ack,
    output logic [3:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overrun
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {SCAN, CONFIRM, HELD, RELEASE} state_t;

    state_t                  state, state_n;
    logic [3:0]              row_p0, row_p1;
    logic [SCAN_DIV_W-1:0]   div;
    logic                    tick;
    logic [1:0]              col_idx, col_n;
    logic [3:0]              cnt, cnt_n;
    logic [3:0]              pat, pat_n;
    logic                    capture;

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [1:0] first_low(input logic [3:0] p);
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!p[i]) first_low = 2'(i);
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div <= '0;
        else       div <= div + SCAN_DIV_W'(1);
    end

    assign tick = &div;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        col_n   = col_idx;
        capture = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_p1 == 4'hF) begin
                        col_n = col_idx + 2'd1;
                    end else begin
                        pat_n   = row_p1;
                        cnt_n   = 4'd1;
                        state_n = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (row_p1 != pat) begin
                        cnt_n   = 4'd0;
                        state_n = SCAN;
                    end else if (cnt + 4'd1 >= DB_LAST) begin
                        cnt_n   = 4'd0;
                        capture = 1'b1;
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (row_p1 == 4'hF) begin
                        cnt_n   = 4'd1;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_p1 != 4'hF) begin
                        cnt_n   = 4'd0;
                        state_n = HELD;
                    end else if (cnt + 4'd1 >= DB_LAST) begin
                        cnt_n   = 4'd0;
                        col_n   = col_idx + 2'd1;
                        state_n = SCAN;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Stage p2: FSM state and registered consumer-facing outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            cnt       <= 4'd0;
            pat       <= 4'hF;
            col_idx   <= 2'd0;
            col_sel   <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pat      <= pat_n;
            col_idx  <= col_n;
            col_sel  <= ~(4'b0001 << col_n);
            key_down <= (state_n == HELD) || (state_n == RELEASE);
            if (capture) begin
                key_code  <= {first_low(pat), col_idx};
                key_valid <= 1'b1;
                // An acknowledge landing with the new key consumes the old one cleanly.
                overrun   <= key_ack ? 1'b0 : (overrun | key_valid);
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: emulates a 4x4 key matrix and compares every cycle against a
// tick-level run-length model of the scanner, plus directed scenario checks.
module tb_keypad_scan;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic        key_ack;
    logic [3:0]  col_sel;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic        overrun;

    logic [15:0] keys;
    int          ack_rate;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          m_div, m_col, m_rel;
    logic [3:0]  m_hist[$];
    bit          m_down, m_valid, m_over;
    logic [3:0]  m_code;

    keypad_scan #(.SCAN_DIV_W(W), .DEBOUNCE_TICKS(D)) dut (
        .clk(clk), .reset(reset), .row(row), .key_ack(key_ack),
        .col_sel(col_sel), .key_code(key_code), .key_valid(key_valid),
        .key_down(key_down), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_sel[c]) row[r] = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] keypad_rows(input int col);
        logic [3:0] r = 4'hF;
        for (int i = 0; i < 4; i++)
            if (keys[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [3:0] cs = ~(4'b0001 << m_col);
        return {cs, m_code, m_valid, m_down, m_over};
    endfunction

    function automatic bit would_capture();
        logic [3:0] s = keypad_rows(m_col);
        return (m_div == 15) && !m_down && (m_hist.size() == D-1) && (s == m_hist[0]);
    endfunction

    task automatic model_reset();
        m_div = 0; m_col = 0; m_rel = 0;
        m_hist.delete();
        m_down = 0; m_valid = 0; m_over = 0; m_code = 4'd0;
    endtask

    // One clock edge of the model: scanning decisions are made only on scan ticks.
    task automatic model_edge();
        logic [3:0] s;
        bit cap = 0;
        int low;
        s = keypad_rows(m_col);
        if (m_div == 15) begin
            if (!m_down) begin
                if (m_hist.size() == 0) begin
                    if (s == 4'hF) m_col = (m_col + 1) % 4;
                    else           m_hist.push_back(s);
                end else if (s == m_hist[0]) begin
                    m_hist.push_back(s);
                    if (m_hist.size() == D) begin
                        cap = 1; m_down = 1; m_rel = 0;
                    end
                end else begin
                    m_hist.delete();
                end
            end else begin
                if (s == 4'hF) begin
                    m_rel++;
                    if (m_rel == D) begin
                        m_down = 0; m_rel = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    m_rel = 0;
                end
            end
        end
        if (cap) begin
            low = 0;
            for (int i = 3; i >= 0; i--) if (!m_hist[0][i]) low = i;
            m_code  = 4'(low*4 + m_col);
            m_over  = key_ack ? 0 : (m_over | m_valid);
            m_valid = 1;
            m_hist.delete();
        end else if (key_ack && m_valid) begin
            m_valid = 0; m_over = 0;
        end
        m_div = (m_div + 1) % 16;
    endtask

    task automatic step();
        if (ack_rate > 0) key_ack = ($urandom_range(99) < ack_rate);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outputs", {5'd0, col_sel, key_code, key_valid, key_down, overrun}, {5'd0, exp_vec()});
    endtask

    task automatic run_ticks(input int n);
        bit was;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < 16; k++) begin
                was = (m_div == 15);
                step();
                if (was) break;
            end
        end
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"},   col_sel,   4'b1110);
        chk({tag, "_code"},  key_code,  4'd0);
        chk({tag, "_valid"}, key_valid, 1'b0);
        chk({tag, "_down"},  key_down,  1'b0);
        chk({tag, "_ovr"},   overrun,   1'b0);
    endtask

    initial begin
        logic [3:0] idle_seq [4];
        bit found;
        int sel, c, r1, r2;
        idle_seq[0] = 4'b1101; idle_seq[1] = 4'b1011;
        idle_seq[2] = 4'b0111; idle_seq[3] = 4'b1110;

        reset = 1'b1; keys = '0; key_ack = 1'b0; ack_rate = 0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Idle scanning walks the columns once per tick.
        for (int i = 0; i < 4; i++) begin
            run_ticks(1);
            chk("idle_col", col_sel, idle_seq[i]);
        end
        chk("idle_valid", key_valid, 1'b0);

        // Bounce on key 0: two ticks low then released.
        keys = 16'h0001;
        run_ticks(2);
        keys = '0;
        run_ticks(1);
        chk("bounce_col_hold", col_sel, 4'b1110);
        chk("bounce_valid", key_valid, 1'b0);
        run_ticks(1);
        chk("bounce_col_next", col_sel, 4'b1101);

        // Stable press of row2/col1.
        keys = 16'h0200;
        run_ticks(3);
        chk("press9_early", key_valid, 1'b0);
        run_ticks(1);
        chk("press9_valid", key_valid, 1'b1);
        chk("press9_code",  key_code,  4'h9);
        chk("press9_down",  key_down,  1'b1);
        run_ticks(20);
        chk("held9_valid", key_valid, 1'b1);
        chk("held9_ovr",   overrun,   1'b0);
        pulse_ack();
        chk("ack9_valid", key_valid, 1'b0);
        chk("ack9_code_hold", key_code, 4'h9);
        keys = '0;
        run_ticks(4);
        chk("release9_down", key_down, 1'b0);

        // Two keys without acknowledge produce an overrun.
        keys = 16'h0020; run_ticks(10);
        keys = '0;       run_ticks(6);
        keys = 16'h0400; run_ticks(10);
        keys = '0;       run_ticks(6);
        chk("ovr_code",  key_code,  4'hA);
        chk("ovr_valid", key_valid, 1'b1);
        chk("ovr_flag",  overrun,   1'b1);
        pulse_ack();
        chk("ovr_ack_valid", key_valid, 1'b0);
        chk("ovr_ack_flag",  overrun,   1'b0);

        // Acknowledge coinciding with the capture of a second key.
        keys = 16'h0008; run_ticks(12);
        keys = '0;       run_ticks(6);
        chk("first_code", key_code, 4'h3);
        keys = 16'h0040;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (would_capture()) begin
                found = 1;
                pulse_ack();
            end else begin
                step();
            end
        end
        chk("ack_capture_found", found, 1'b1);
        chk("same_cycle_valid", key_valid, 1'b1);
        chk("same_cycle_code",  key_code,  4'h6);
        chk("same_cycle_ovr",   overrun,   1'b0);
        pulse_ack();
        keys = '0;
        run_ticks(6);

        // Reset while holding key 9, key still held afterwards.
        keys = 16'h0200;
        run_ticks(12);
        chk("pre_reset_down", key_down, 1'b1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_ticks(4);
        chk("redetect_early", key_valid, 1'b0);
        run_ticks(1);
        chk("redetect_valid", key_valid, 1'b1);
        chk("redetect_code",  key_code,  4'h9);
        keys = '0;
        run_ticks(6);

        // Randomized key activity with sporadic acknowledges.
        ack_rate = 3;
        for (int e = 0; e < 60; e++) begin
            sel = $urandom_range(9);
            keys = '0;
            if (sel >= 3 && sel <= 7) begin
                keys[$urandom_range(15)] = 1'b1;
            end else if (sel == 8) begin
                c = $urandom_range(3); r1 = $urandom_range(3); r2 = $urandom_range(3);
                keys[r1*4+c] = 1'b1;
                keys[r2*4+c] = 1'b1;
            end else if (sel == 9) begin
                keys[$urandom_range(15)] = 1'b1;
                keys[$urandom_range(15)] = 1'b1;
            end
            run_ticks($urandom_range(8, 1));
        end
        ack_rate = 0;
        key_ack = 1'b0;
        keys = '0;
        run_ticks(8);
        pulse_ack();
        chk("final_valid", key_valid, 1'b0);
        chk("final_down",  key_down,  1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV_W, default 15, meaning scan tick period is 2^SCAN_DIV_W clocks.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, meaning consecutive matching scan ticks needed to accept a press or release (legal 2..15).
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port row  input  4  matrix row lines, active-low, pulled up, asynchronous to clk.
REQ-006 SHALL have port key_ack  input  1  one-cycle read strobe from consumer.
REQ-007 SHALL have port col_sel  output  4  column drive, active-low one-cold.
REQ-008 SHALL have port key_code  output  4  accepted key, code = row_idx*4 + col_idx.
REQ-009 SHALL have port key_valid  output  1  unread key pending.
REQ-010 SHALL have port key_down  output  1  debounced key currently held.
REQ-011 SHALL have port overrun  output  1  sticky, key accepted while previous unread.

Function
REQ-012 SHALL pass row through a two-flop synchronizer (reset value 4'hF); all decisions use the synchronized value.
REQ-013 SHALL run a free-running SCAN_DIV_W-bit divider; a tick is the cycle the divider equals all-ones.
REQ-014 SHALL implement FSM states SCAN, CONFIRM, HELD, RELEASE; all transitions and counter updates happen only on ticks.
REQ-015 SCAN: row == 4'hF -> column index increments mod 4 (col_sel 1110->1101->1011->0111->1110); otherwise latch row pattern, debounce count = 1, go CONFIRM, column frozen.
REQ-016 CONFIRM: row equals latched pattern -> count+1; row differs -> go SCAN without advancing column, count cleared.
REQ-017 CONFIRM reaching DEBOUNCE_TICKS SHALL capture key (lowest-index low row wins on multiple rows), go HELD, set key_down; key_valid/key_code update in the cycle after that tick.
REQ-018 HELD: row == 4'hF -> count = 1, go RELEASE; otherwise stay; no auto-repeat.
REQ-019 RELEASE: row == 4'hF -> count+1; reaching DEBOUNCE_TICKS clears key_down, advances column, goes SCAN; row != 4'hF -> back to HELD.
REQ-020 key_ack SHALL clear key_valid and overrun the following cycle; key_ack with key_valid=0 is ignored.
REQ-021 Capture while key_valid=1 and no key_ack SHALL overwrite key_code and set overrun.
REQ-022 Capture in same cycle as key_ack SHALL leave key_valid=1, new key_code, overrun=0.
REQ-023 key_code SHALL hold its last value after acknowledge.
REQ-024 All outputs SHALL be registered; no combinational path from row or key_ack to any output.

Reset
REQ-025 On reset assertion, immediately (asynchronously): col_sel=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0, divider=0, counts=0, state=SCAN, synchronizer=4'hF.
REQ-026 Reset mid-operation (any state) SHALL abandon the key in progress; a key still held after reset release is re-detected as a new press through full debounce.

Verification (SCAN_DIV_W=4, DEBOUNCE_TICKS=4)
REQ-027 Reset then idle rows=4'hF -> col_sel 1110, every 16 clocks 1101,1011,0111,1110; all other outputs 0.
REQ-028 Press row2/col1 stable (row[2] low only while col_sel[1]=0) -> key_valid=1, key_code=4'h9, key_down=1 after 4 ticks; held 20 ticks -> no further capture; key_ack -> key_valid=0 next cycle.
REQ-029 Bounce: row[0] low on 2 ticks then high on col0 -> key_valid stays 0, scanning resumes from col0 to col1 on next idle tick.
REQ-030 Press/release key 0x5 then key 0xA without ack -> key_code=4'hA, key_valid=1, overrun=1; key_ack -> both flags 0.
REQ-031 key_ack pulsed the cycle key_valid rises for a second key -> key_valid=1, key_code=second key, overrun=0.
REQ-032 Reset asserted while in HELD with key 0x9 held, then released with key still held -> outputs reset that cycle; key_valid reasserts with 4'h9 only after a full 4-tick debounce.
